// File: rtl/dmem_if.sv
// Request/response channel between the core MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency, byte-addressed, little-endian 64-bit data memory with alignment and range checks.
//  state  | meaning
//  S_IDLE | ready for a request; latches it on the accept edge
//  S_WAIT | latency down-counter running; access performed when it reaches 0
//  S_RESP | response held on the bus until resp_ready
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output logic   busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we, lat_uns;
  logic [1:0]  lat_size;
  logic [63:0] lat_addr, lat_wdata;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [63:0] mem [DEPTH];

  logic             accept, do_access;
  logic [2:0]       lane;
  logic [5:0]       bit_sh;
  logic [IDX_W-1:0] widx;
  logic             misalign, range_err, acc_err;
  logic [63:0]      word, word_sh, load_val, be_base, be_mask, store_word;

  assign accept    = (state == S_IDLE) && bus.req_valid;
  assign do_access = (state == S_WAIT) && (cnt == 4'd0);

  // Access datapath works only from the latched request, never from live bus inputs.
  always_comb begin
    lane      = lat_addr[2:0];
    bit_sh    = {lane, 3'b000};
    widx      = lat_addr[3 +: IDX_W];
    range_err = (lat_addr[63:3] >= 61'(DEPTH));
    case (lat_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = lane[0];
      2'd2:    misalign = |lane[1:0];
      default: misalign = |lane;
    endcase
    acc_err = misalign | range_err;
    word    = mem[widx];
    word_sh = word >> bit_sh;
    case (lat_size)
      2'd0: begin
        load_val = lat_uns ? {56'd0, word_sh[7:0]} : {{56{word_sh[7]}}, word_sh[7:0]};
        be_base  = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        load_val = lat_uns ? {48'd0, word_sh[15:0]} : {{48{word_sh[15]}}, word_sh[15:0]};
        be_base  = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        load_val = lat_uns ? {32'd0, word_sh[31:0]} : {{32{word_sh[31]}}, word_sh[31:0]};
        be_base  = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        load_val = word_sh;
        be_base  = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
    be_mask    = be_base << bit_sh;
    store_word = (word & ~be_mask) | ((lat_wdata << bit_sh) & be_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req_valid)  state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0)    state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    busy           = (state != S_IDLE);
  end

  // WAIT spans LATENCY cycles, so resp_valid rises LATENCY edges after the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 64'd0;
      lat_wdata <= 64'd0;
      rdata_q   <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_uns   <= bus.req_unsigned;
        lat_size  <= bus.req_size;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        cnt       <= 4'(LATENCY - 1);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || lat_we) ? 64'd0 : load_val;
      end
    end
  end

  // A reset landing on the access edge cancels the store.
  always_ff @(posedge clk) begin
    if (!rst && do_access && lat_we && !acc_err) mem[widx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a byte-array reference model.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  dmem_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] model_mem [DEPTH*8];

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void model_access(input logic we, input logic [63:0] addr, input logic [1:0] size,
                                       input logic uns, input logic [63:0] wdata,
                                       output logic [63:0] rd, output logic err);
    int n;
    logic [63:0] val;
    n   = 1 << size;
    err = ((addr % 64'(n)) != 64'd0) || (addr >= 64'(DEPTH * 8));
    rd  = 64'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        val = 64'd0;
        for (int i = 0; i < n; i++) val = val | (64'(model_mem[int'(addr) + i]) << (8 * i));
        if (!uns && n < 8 && val[8*n-1]) val = val | (~64'd0 << (8 * n));
        rd = val;
      end
    end
  endfunction

  task automatic drive_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
  endtask

  task automatic scramble_inputs();
    bus.req_we       = 1'($urandom);
    bus.req_addr     = {$urandom, $urandom};
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_wdata    = {$urandom, $urandom};
  endtask

  // One full transaction: accept, measure latency, optional backpressure, then handshake.
  task automatic txn(input logic we, input logic [63:0] addr, input logic [1:0] size, input logic uns,
                     input logic [63:0] wdata, input int hold,
                     output logic [63:0] rd, output logic er);
    int k;
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.resp_ready = 1'b0;
    drive_req(we, addr, size, uns, wdata);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble_inputs();
    k = 0;
    while (!bus.resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 64'(k), 64'(LAT));
    rd = bus.resp_rdata;
    er = bus.resp_err;
    chk("req_ready_resp", 64'(bus.req_ready), 64'd0);
    chk("busy_resp", 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      scramble_inputs();
      chk("hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_rdata", bus.resp_rdata, rd);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("taken_valid", 64'(bus.resp_valid), 64'd0);
    chk("taken_req_ready", 64'(bus.req_ready), 64'd1);
    chk("taken_busy", 64'(busy), 64'd0);
  endtask

  task automatic txn_model(input logic we, input logic [63:0] addr, input logic [1:0] size, input logic uns,
                           input logic [63:0] wdata, input int hold);
    logic [63:0] rd, exp_rd;
    logic        er, exp_er;
    model_access(we, addr, size, uns, wdata, exp_rd, exp_er);
    txn(we, addr, size, uns, wdata, hold, rd, er);
    chk("model_rdata", rd, exp_rd);
    chk("model_err", 64'(er), 64'(exp_er));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, exp_rd, a;
    logic        er, exp_er;
    logic [1:0]  sz;
    int          k, r;
    int          acc [$];
    logic        rdy;

    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 64'd0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata = 64'd0;

    vecs[0]  = '{1'b1, 64'h10,        2'd3, 1'b0, 64'h1122334455667788, 64'h0,                1'b0};
    vecs[1]  = '{1'b0, 64'h10,        2'd3, 1'b0, 64'h0,                64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b0, 64'h10,        2'd0, 1'b0, 64'h0,                64'hFFFFFFFFFFFFFF88, 1'b0};
    vecs[3]  = '{1'b0, 64'h10,        2'd0, 1'b1, 64'h0,                64'h88,               1'b0};
    vecs[4]  = '{1'b1, 64'h12,        2'd1, 1'b0, 64'h123456789ABCBEEF, 64'h0,                1'b0};
    vecs[5]  = '{1'b0, 64'h10,        2'd3, 1'b0, 64'h0,                64'h11223344BEEF7788, 1'b0};
    vecs[6]  = '{1'b0, 64'h06,        2'd2, 1'b0, 64'h0,                64'h0,                1'b1};
    vecs[7]  = '{1'b1, 64'(DEPTH*8),  2'd3, 1'b0, 64'hDEADBEEFDEADBEEF, 64'h0,                1'b1};
    vecs[8]  = '{1'b0, 64'h10,        2'd3, 1'b1, 64'h0,                64'h11223344BEEF7788, 1'b0};
    vecs[9]  = '{1'b0, 64'h14,        2'd2, 1'b0, 64'h0,                64'h11223344,         1'b0};
    vecs[10] = '{1'b0, 64'h12,        2'd1, 1'b0, 64'h0,                64'hFFFFFFFFFFFFBEEF, 1'b0};
    vecs[11] = '{1'b0, 64'h17,        2'd0, 1'b0, 64'h0,                64'h11,               1'b0};
    vecs[12] = '{1'b1, 64'h1A,        2'd2, 1'b0, 64'hCAFEF00D,         64'h0,                1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    chk("rst_err", 64'(bus.resp_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Give every word a known value so later loads are fully predictable.
    for (int i = 0; i < DEPTH; i++)
      txn_model(1'b1, 64'(i * 8), 2'd3, 1'b0, {$urandom, $urandom}, 0);

    for (int i = 0; i < 13; i++) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, exp_rd, exp_er);
      txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, 0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
    end

    // Backpressure: response held 5 cycles
    txn(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 5, rd, er);
    chk("bp_rdata", rd, 64'h11223344BEEF7788);

    // Back-to-back requests with resp_ready held high
    @(negedge clk);
    bus.resp_ready = 1'b1;
    drive_req(1'b0, 64'h10, 2'd3, 1'b0, 64'h0);
    for (int e = 0; e < 4 * (LAT + 2); e++) begin
      rdy = bus.req_ready;
      if (bus.resp_valid) chk("b2b_rdata", bus.resp_rdata, 64'h11223344BEEF7788);
      @(posedge clk);
      if (rdy) acc.push_back(e);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    bus.resp_ready = 1'b0;
    chk("b2b_drain", 64'(busy), 64'd0);
    chk("b2b_accepts", 64'(acc.size() >= 2), 64'd1);
    if (acc.size() >= 2) chk("b2b_spacing", 64'(acc[1] - acc[0]), 64'(LAT + 2));

    // Reset during WAIT: one cycle after accept, and on the would-be access edge
    for (int d = 1; d <= LAT; d++) begin
      txn_model(1'b1, 64'h20, 2'd0, 1'b0, 64'h55, 0);
      @(negedge clk);
      drive_req(1'b1, 64'h20, 2'd0, 1'b0, 64'hAA);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("wait_busy", 64'(busy), 64'd1);
      for (int j = 1; j < d; j++) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("wait_rst_busy", 64'(busy), 64'd0);
      chk("wait_rst_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      txn_model(1'b0, 64'h20, 2'd0, 1'b1, 64'h0, 0);
    end

    // Reset in RESP: store already committed, response dropped
    @(negedge clk);
    drive_req(1'b1, 64'h28, 2'd0, 1'b0, 64'hCC);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("resp_rst_reach", 64'(bus.resp_valid), 64'd1);
    model_access(1'b1, 64'h28, 2'd0, 1'b0, 64'hCC, exp_rd, exp_er);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("resp_rst_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    txn_model(1'b0, 64'h28, 2'd0, 1'b1, 64'h0, 0);

    // Reset and request on the same edge: nothing accepted
    @(negedge clk);
    rst = 1'b1;
    drive_req(1'b1, 64'h30, 2'd3, 1'b0, 64'h0123456789ABCDEF);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_busy", 64'(busy), 64'd0);
    txn_model(1'b0, 64'h30, 2'd3, 1'b0, 64'h0, 0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r == 0)      a = 64'(DEPTH * 8) + 64'($urandom_range(0, 1000));
      else if (r == 1) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else begin
        a = 64'($urandom_range(0, DEPTH * 8 - 1));
        if (r >= 4) a = a & ~(64'((1 << sz) - 1));
      end
      txn_model(1'($urandom), a, sz, 1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
